// File: rtl/dfp_ilogb128.sv
// ---------------------------------------------------------------------------
// dfp_ilogb128
// Iterative decimal-float ilogb for IEEE 754 decimal128 (DPD encoding).
// Returns the adjusted decimal exponent n of the operand as a signed 32-bit
// integer, i.e. the n with 1 <= |a| / 10^n < 10. This is the companion of the
// DFP128 scaleb unit: ilogb splits a value and scaleb rebuilds it.
//
// The operand is captured on an accepted ld. It is then unpacked into
// exponent, 34 BCD digits and special flags. Finally a digit-serial scan
// counts the leading zero digits, DPC digits per cycle.
//
// Parameters:
//   DPC      BCD digits examined per scan cycle (1 or 2)
//   N        significand digit count (34 for decimal128)
//
// Ports:
//   clk      in   1    clock, rising edge
//   rst_n    in   1    synchronous active-low reset
//   ce       in   1    clock enable; low freezes all state including outputs
//   ld       in   1    start request, sampled only in IDLE with ce high
//   a        in   128  decimal128 operand, captured when ld is accepted
//   o        out  32   signed result, held until the next accepted ld
//   done     out  1    one-cycle (ce-cycle) pulse when o becomes valid
//   busy     out  1    high while an operation is in flight
//   invalid  out  1    set with done for zero, infinity or NaN operands
//
// Configuration macro:
//   DFP_ILOGB_EARLYOUT_EN  defined   -> variable latency. The scan stops at the
//                                      first nonzero digit. Specials take one
//                                      scan cycle.
//                          undefined -> fixed latency of ceil(N/DPC) scan
//                                      cycles for every operand.
// ---------------------------------------------------------------------------
module dfp_ilogb128 #(
   parameter int DPC = 2,
   parameter int N   = 34
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         ce,
   input  logic         ld,
   input  logic [127:0] a,
   output logic [31:0]  o,
   output logic         done,
   output logic         busy,
   output logic         invalid
);

   localparam int          SW        = N * 4;
   localparam int          SCAN_CYC  = (N + DPC - 1) / DPC;
   localparam logic [5:0]  SCAN_LAST = 6'(SCAN_CYC - 1);
   localparam logic [5:0]  LZD_STEP  = 6'(DPC);
   localparam logic [31:0] BIAS      = 32'd6143;

   typedef enum logic [1:0] {IDLE, LOAD, SCAN} state_t;

   state_t        r_state;
   state_t        w_stateNext;

   logic [126:0]  r_a;
   logic [SW-1:0] r_sr;
   logic [15:0]   r_exp;
   logic          r_isNan;
   logic          r_isInf;
   logic [5:0]    r_lzd;
   logic [5:0]    r_cnt;
   logic          r_found;

   logic [4:0]    w_comb;
   logic [1:0]    w_expMsb;
   logic [3:0]    w_lead;
   logic [15:0]   w_exp;
   logic [SW-1:0] w_sig;
   logic          w_isNan;
   logic          w_isInf;

   logic [3:0]    w_top;
   logic [3:0]    w_second;
   logic [5:0]    w_lzdNext;
   logic [SW-1:0] w_srNext;
   logic          w_foundNext;
   logic          w_isZero;
   logic          w_scanEnd;
   logic [31:0]   w_diff;
   logic [31:0]   w_result;
   logic          w_invalid;

   // The sign never affects the result, so the sign bit is never captured.
   logic          w_unusedSign;
   assign w_unusedSign = a[127];

   // Densely-packed-decimal declet to three BCD digits. Bits v, w, x and
   // s, t select which digits are large (8 or 9) and where their low bits sit.
   function automatic logic [11:0] dpdDecode(input logic [9:0] dec);
      logic p, q, r, s, t, u, v, w, x, y;
      logic [11:0] res;
      {p, q, r, s, t, u, v, w, x, y} = dec;
      res = {1'b0, p, q, r, 1'b0, s, t, u, 1'b0, w, x, y};
      if (v) begin
         case ({w, x})
            2'b00:   res = {1'b0, p, q, r, 1'b0, s, t, u, 3'b100, y};
            2'b01:   res = {1'b0, p, q, r, 3'b100, u, 1'b0, s, t, y};
            2'b10:   res = {3'b100, r, 1'b0, s, t, u, 1'b0, p, q, y};
            default: begin
               case ({s, t})
                  2'b00:   res = {3'b100, r, 3'b100, u, 1'b0, p, q, y};
                  2'b01:   res = {3'b100, r, 1'b0, p, q, u, 3'b100, y};
                  2'b10:   res = {1'b0, p, q, r, 3'b100, u, 3'b100, y};
                  default: res = {3'b100, r, 3'b100, u, 3'b100, y};
               endcase
            end
         endcase
      end
      return res;
   endfunction

   // Unpack the captured operand. The 5-bit combination field carries
   // either the two exponent MSBs plus a small leading digit (0-7), or, when
   // it starts with 11, the exponent MSBs plus a large leading digit (8/9).
   // The patterns 11110 and 11111 mark infinity and NaN. The bit after the
   // combination field separates qNaN from sNaN. Both are treated alike here.
   always_comb begin
      w_comb  = r_a[126:122];
      w_isInf = (w_comb == 5'b11110);
      w_isNan = (w_comb == 5'b11111);
      if (w_comb[4:3] != 2'b11) begin
         w_expMsb = w_comb[4:3];
         w_lead   = {1'b0, w_comb[2:0]};
      end else begin
         w_expMsb = w_comb[2:1];
         w_lead   = {3'b100, w_comb[0]};
      end
      w_exp = {2'b00, w_expMsb, r_a[121:110]};
      w_sig = '0;
      w_sig[SW-1 -: 4] = w_lead;
      for (int g = 0; g < 11; g++) begin
         w_sig[g*12 +: 12] = dpdDecode(r_a[g*10 +: 10]);
      end
   end

   // One scan step. Once a nonzero digit has been seen, lzd and sr freeze.
   // This matters only for the fixed-latency build, which keeps cycling
   // after the digit is found.
   assign w_top    = r_sr[SW-1 -: 4];
   assign w_second = r_sr[SW-5 -: 4];
   assign w_isZero = ~|r_sr;

   always_comb begin
      w_lzdNext   = r_lzd;
      w_srNext    = r_sr;
      w_foundNext = r_found;
      if (!r_found) begin
         if (w_top != 4'd0) begin
            w_foundNext = 1'b1;
         end else if ((DPC == 2) && (w_second != 4'd0)) begin
            w_lzdNext   = r_lzd + 6'd1;
            w_foundNext = 1'b1;
         end else begin
            w_lzdNext = r_lzd + LZD_STEP;
            w_srNext  = r_sr << (4 * DPC);
         end
      end
   end

   // Decide the cycle that finishes the scan. In the early-out build the
   // counter bound is a backstop only: a nonzero operand always stops
   // within ceil(N/DPC) cycles anyway.
   always_comb begin
`ifdef DFP_ILOGB_EARLYOUT_EN
      w_scanEnd = r_isNan | r_isInf | w_isZero | w_foundNext | (r_cnt == SCAN_LAST);
`else
      w_scanEnd = (r_cnt == SCAN_LAST);
`endif
   end

   // Result selection in priority order: NaN, infinity, zero, finite.
   // The unsigned exponent minus bias minus lzd yields a two's-complement
   // value in 32 bits.
   always_comb begin
      w_diff = {16'd0, r_exp} - BIAS - {26'd0, w_lzdNext};
      if (r_isNan) begin
         w_result  = 32'h8000_0000;
         w_invalid = 1'b1;
      end else if (r_isInf) begin
         w_result  = 32'h7FFF_FFFF;
         w_invalid = 1'b1;
      end else if (w_isZero) begin
         w_result  = 32'h8000_0000;
         w_invalid = 1'b1;
      end else begin
         w_result  = w_diff;
         w_invalid = 1'b0;
      end
   end

   // State register. Reset wins over ce so a stalled unit can still be reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else if (ce) begin
         r_state <= w_stateNext;
      end
   end

   // Next-state logic: IDLE -> LOAD on ld, LOAD -> SCAN, SCAN -> IDLE at end.
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE:    if (ld) w_stateNext = LOAD;
         LOAD:    w_stateNext = SCAN;
         SCAN:    if (w_scanEnd) w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   // Output logic: busy covers every non-IDLE state. It therefore falls on
   // the same edge that raises done.
   always_comb begin
      busy = (r_state != IDLE);
   end

   // Datapath. The operand is captured on acceptance, and a is not looked
   // at afterwards. LOAD then registers the unpacked fields. Each SCAN
   // cycle advances the scan, and the final SCAN cycle publishes the result.
   // done is cleared on every other ce edge, so it stays high through
   // ce-low cycles.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_sr    <= '0;
         r_exp   <= '0;
         r_isNan <= 1'b0;
         r_isInf <= 1'b0;
         r_lzd   <= '0;
         r_cnt   <= '0;
         r_found <= 1'b0;
         o       <= '0;
         done    <= 1'b0;
         invalid <= 1'b0;
      end else if (ce) begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (ld) r_a <= a[126:0];
            end
            LOAD: begin
               r_sr    <= w_sig;
               r_exp   <= w_exp;
               r_isNan <= w_isNan;
               r_isInf <= w_isInf;
               r_lzd   <= '0;
               r_cnt   <= '0;
               r_found <= 1'b0;
            end
            SCAN: begin
               r_sr    <= w_srNext;
               r_lzd   <= w_lzdNext;
               r_found <= w_foundNext;
               r_cnt   <= r_cnt + 6'd1;
               if (w_scanEnd) begin
                  o       <= w_result;
                  invalid <= w_invalid;
                  done    <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/dfp_ilogb128.md
# dfp_ilogb128

- Iterative decimal-float ilogb: takes a DFP128 operand and returns its adjusted decimal exponent as a signed 32-bit integer, i.e. the value n with 1 ≤ |a|/10^n < 10.
- It is the inverse companion of the DFP128 scaleb unit.
- It sits in the DFPU beside scaleb. The pair lets software normalise and denormalise decimal values: split with ilogb, rebuild with scaleb.
- It uses a start/done handshake with a digit-serial leading-zero-digit scan.

## Interface
Parameters:
- DPC, default 2: BCD digits examined per scan cycle. Legal values are 1 and 2.
- N, default 34: significand digit count. Fixed for DFP128.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- ce  in  1  clock enable. When low, all state, including the outputs, is frozen.
- ld  in  1  start request. Sampled only in IDLE with ce high.
- a  in  128  DFP128 operand. Captured when ld is accepted.
- o  out  32  signed result. Held until the next accepted ld.
- done  out  1  one-cycle pulse marking the cycle o becomes valid.
- busy  out  1  high from the edge that accepts ld until the edge that raises done.
- invalid  out  1  set with done when a is zero, infinity or NaN.

## Operation
- The operand is unpacked with DFPUnpack128 into sign, exp (16-bit), sig (N×4-bit BCD), nan/qnan/snan and infinity. The bias is 14'h17FF.
- The significand is interpreted as d.ddd…, with the leading digit at sig[N*4-1:N*4-4].
- States: IDLE → LOAD → SCAN → IDLE.
  - IDLE: busy=0. On ld&ce: capture a, go to LOAD, busy=1.
  - LOAD: register the unpacked fields into a shift register sr (N×4) and exp. Clear the digit counter lzd (6-bit) and the scan count. Go to SCAN.
  - SCAN, each ce cycle: inspect the top DPC digits of sr.
    - If the top digit is nonzero: stop at this digit.
    - With DPC=2, if the top digit is 0 and the second is nonzero: lzd+=1 and stop.
    - Otherwise: lzd+=DPC and shift sr left by 4·DPC.
    - The cycle that completes the scan (see Configuration) writes o, invalid and done=1, and returns to IDLE.
- Result selection, priority order:
  - NaN (qNaN or sNaN): o=32'h80000000, invalid=1.
  - Infinity: o=32'h7FFFFFFF, invalid=1.
  - Zero significand (all N digits 0): o=32'h80000000, invalid=1.
  - Otherwise: o = zero-extended exp − 32'd6143 − lzd, computed in 32-bit two's complement; invalid=0.
- Sign is ignored: ilogb(−x) = ilogb(x).
- Result range for finite nonzero operands: −6176 … +6144.
- The operand must not be sampled after acceptance. Changes on a during busy have no effect.
- ld while busy is ignored. It is not queued.

## Timing
- Reset values: state=IDLE, o=32'd0, done=0, busy=0, invalid=0.
- Reset is taken even while ce is low. Reset mid-scan aborts the operation: no done pulse, and o returns to 0.
- Let ld be accepted at edge k and let S be the number of SCAN cycles. Then:
  - done rises on edge k+1+S and falls on the next ce edge.
  - busy falls on the same edge that done rises.
- A new ld is accepted on the edge that done falls at the earliest (state IDLE), which gives back-to-back throughput of one operation per S+2 cycles.
- A cycle with ce low adds exactly one cycle to every later timing point. done stays high through ce-low cycles.

## Configuration
- DFP_ILOGB_EARLYOUT_EN defined (variable latency):
  - SCAN ends in the cycle the first nonzero digit is found, so S = floor(lzd/DPC)+1.
  - NaN, infinity and zero end after one SCAN cycle (S=1). Zero is detected by an all-digit OR in that cycle.
- Not defined (fixed latency):
  - SCAN always runs S = ceil(N/DPC) cycles: 17 for DPC=2, 34 for DPC=1.
  - lzd freezes once a nonzero digit is found, and later shifts are ignored.
  - Special operands also run the full S.
  - done always occurs at k+1+ceil(N/DPC).

## Test plan
- Basic case: exp=16'h17FF, sig leading digit 1, rest 0 → o=0, invalid=0. done at k+2 with EARLYOUT and DPC=2, or at k+18 without.
- Odd-position leading digit: exp=16'h17FF+5, top digits 0,0,0,7 → lzd=3, o=2. EARLYOUT, DPC=2: done at k+3. DPC=1: done at k+5.
- Minimum result: exp=0, only the last digit =1 → lzd=33, o=32'hFFFFE7E0 (−6176), invalid=0.
- Special operands:
  - +0 → o=32'h80000000, invalid=1.
  - −inf → o=32'h7FFFFFFF, invalid=1.
  - qNaN → o=32'h80000000, invalid=1.
  - sNaN → o=32'h80000000, invalid=1.
- Handshake:
  - ld pulsed again mid-scan with a different a → ignored; the result matches the first operand.
  - ce low for 3 cycles mid-scan → done is delayed by exactly 3 cycles.
- Reset: rst_n low for one cycle mid-scan → next cycle busy=0, o=0, and no done pulse. A subsequent ld completes normally.
